// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, timing constants
// and the parity rule used by both directions.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned SAMPLE_MID = 7;
    localparam int unsigned DATA_BITS  = 8;

    localparam logic PAR_ODD  = 1'b0;
    localparam logic PAR_EVEN = 1'b1;

    // Parity bit a transmitter appends for the selected parity sense.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input logic sel);
        return (sel == PAR_EVEN) ? ^d : ~^d;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line with a registered falling-edge pulse.
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_sync,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            s3   <= 1'b1;
            fall <= 1'b0;
        end else begin
            s1   <= rx;
            s2   <= s1;
            s3   <= s2;
            fall <= s3 & ~s2;
        end
    end

    assign rx_sync = s2;

endmodule

// File: rtl/uart_rx.sv
// 16x oversampled UART receiver: start, 8 data bits MSB-first, parity, stop.
// Optional macro UART_RX_MAJORITY_EN: 2-of-3 vote over ticks SAMPLE_MID..SAMPLE_MID+2.
module uart_rx #(
    parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE,
    parameter int unsigned SAMPLE_MID = uart_pkg::SAMPLE_MID
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_clk,
    input  logic       p_sel,
    input  logic       rx,
    output logic [7:0] d_out,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       busy
);

    import uart_pkg::*;

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [TW-1:0] TICK_DECIDE = TW'(SAMPLE_MID + 2);
`else
    localparam logic [TW-1:0] TICK_DECIDE = TW'(SAMPLE_MID);
`endif

    uart_state_t state;
    uart_state_t state_next;

    logic                 rx_s;
    logic                 fall;
    logic [TW-1:0]        tick;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;
    logic                 decide;
    logic                 bit_val;

    uart_rx_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .rx      (rx),
        .rx_sync (rx_s),
        .fall    (fall)
    );

    assign busy   = (state != IDLE);
    assign decide = busy && baud_clk && (tick == TICK_DECIDE);

`ifdef UART_RX_MAJORITY_EN
    logic samp_a;
    logic samp_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else if (busy && baud_clk) begin
            if (tick == TW'(SAMPLE_MID))     samp_a <= rx_s;
            if (tick == TW'(SAMPLE_MID + 1)) samp_b <= rx_s;
        end
    end

    assign bit_val = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fall)   state_next = START;
            START:   if (decide) state_next = bit_val ? IDLE : DATA;
            DATA:    if (decide && (bit_cnt == BW'(DATA_BITS - 1))) state_next = PARITY;
            PARITY:  if (decide) state_next = STOP;
            STOP:    if (decide) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counters only run while a frame is in progress; baud_clk low freezes everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick       <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            d_out      <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            rx_valid   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (state == IDLE) begin
                if (fall) begin
                    tick    <= '0;
                    bit_cnt <= '0;
                end
            end else if (baud_clk) begin
                tick <= (tick == TICK_LAST) ? '0 : tick + 1'b1;
            end

            if (decide) begin
                case (state)
                    DATA: begin
                        shreg   <= {shreg[DATA_BITS-2:0], bit_val};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    PARITY: par_bad <= (bit_val != parity_bit(shreg, p_sel));
                    STOP: begin
                        d_out      <= shreg;
                        parity_err <= par_bad;
                        frame_err  <= ~bit_val;
                        rx_valid   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame scenarios plus random frames
// compared against a scoreboard built from the frame contents the bench sends.
module tb_uart_rx;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       baud_clk = 1'b0;
    logic       p_sel = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] d_out;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned tick_now = 0;
    int unsigned baud_div = 0;

    typedef struct {
        logic [7:0]  d;
        logic        pe;
        logic        fe;
        int unsigned t;
    } rec_t;

    rec_t obs_q[$];
    rec_t exp_q[$];

    uart_rx #(.OVERSAMPLE(16), .SAMPLE_MID(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .baud_clk   (baud_clk),
        .p_sel      (p_sel),
        .rx         (rx),
        .d_out      (d_out),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Baud enable: one clk-wide pulse every 4 clocks.
    initial begin
        forever begin
            @(negedge clk);
            baud_clk = (baud_div == 3);
            baud_div = (baud_div + 1) % 4;
        end
    end

    always @(posedge clk) if (baud_clk) tick_now++;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) obs_q.push_back('{d_out, parity_err, frame_err, tick_now});
    end

    initial begin
        #600000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            while (baud_clk !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    // Serialises a frame one bit per 16 ticks; nbits < 11 abandons it part way.
    task automatic send_frame(input logic [7:0] d, input logic psel, input logic flip,
                              input logic stop, input int unsigned nbits);
        logic frame [11];
        int unsigned ones;
        logic good_p;
        ones   = $countones(d);
        good_p = (psel == PAR_EVEN) ? logic'(ones % 2) : logic'((ones + 1) % 2);
        p_sel  = psel;
        frame[0] = 1'b0;
        for (int i = 0; i < 8; i++) frame[1 + i] = d[7 - i];
        frame[9]  = good_p ^ flip;
        frame[10] = stop;
        for (int unsigned i = 0; i < nbits; i++) begin
            rx = frame[i];
            wait_ticks(16);
        end
        if (nbits == 11) exp_q.push_back('{d, flip, ~stop, 0});
    endtask

    task automatic drain_check(input string tag);
        rec_t o;
        rec_t e;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_data"}, o.d, e.d);
            check({tag, "_perr"}, o.pe, e.pe);
            check({tag, "_ferr"}, o.fe, e.fe);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] rd;
        logic rp, rf, rs;

        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", d_out, 8'h00);
        check("rst_valid", rx_valid, 1'b0);
        check("rst_perr", parity_err, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        wait_ticks(16);

        send_frame(8'hA5, PAR_ODD, 1'b0, 1'b1, 11);
        rx = 1'b1;
        wait_ticks(16);
        drain_check("odd_a5");

        send_frame(8'h3C, PAR_EVEN, 1'b1, 1'b1, 11);
        rx = 1'b1;
        wait_ticks(16);
        drain_check("even_flip_3c");

        // Line stays low after a bad stop bit: no second frame may start.
        send_frame(8'hFF, PAR_ODD, 1'b0, 1'b0, 11);
        wait_ticks(48);
        check("ferr_idle_busy", busy, 1'b0);
        drain_check("ferr_ff");
        rx = 1'b1;
        wait_ticks(16);

        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(24);
        check("glitch_busy", busy, 1'b0);
        drain_check("glitch");

        send_frame(8'h01, PAR_ODD, 1'b0, 1'b1, 11);
        send_frame(8'h80, PAR_ODD, 1'b0, 1'b1, 11);
        rx = 1'b1;
        wait_ticks(16);
        check("b2b_gap", (obs_q.size() == 2) ? obs_q[1].t - obs_q[0].t : 0, 176);
        drain_check("b2b");

        send_frame(8'h55, PAR_ODD, 1'b0, 1'b1, 5);
        rx = 1'b0;
        wait_ticks(8);
        check("pre_rst_busy", busy, 1'b1);
        reset = 1'b0;
        rx = 1'b1;
        #1;
        check("mid_rst_dout", d_out, 8'h00);
        check("mid_rst_valid", rx_valid, 1'b0);
        check("mid_rst_perr", parity_err, 1'b0);
        check("mid_rst_ferr", frame_err, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wait_ticks(32);
        send_frame(8'h0F, PAR_ODD, 1'b0, 1'b1, 11);
        rx = 1'b1;
        wait_ticks(16);
        drain_check("after_rst_0f");

        for (int k = 0; k < 20; k++) begin
            rd = 8'($urandom);
            rp = 1'($urandom_range(0, 1));
            rf = ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 3) != 0);
            send_frame(rd, rp, rf, rs, 11);
            rx = 1'b1;
            wait_ticks(16 * $urandom_range(1, 3));
        end
        drain_check("random");
        check("final_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver consuming the single-wire output of the `uart_tx` transmitter. Recovers 11-bit frames (start, 8 data bits MSB-first, parity, stop) using a 16x oversampled baud enable. Presents each byte with a one-cycle valid strobe plus parity and framing error flags to the host-side logic.

## Interface
- `OVERSAMPLE`, default 16: baud enable ticks per bit.
- `SAMPLE_MID`, default 7: tick index within a bit at which the bit is sampled.
- `clk  input  1  system clock`
- `reset  input  1  asynchronous active-low reset`
- `baud_clk  input  1  one-`clk`-wide enable pulse at 16x baud rate`
- `p_sel  input  1  parity select: 0 = odd parity, 1 = even parity (matches `uart_tx`)`
- `rx  input  1  serial line, idle high, asynchronous to `clk``
- `d_out  output  8  last received byte; held until the next frame completes`
- `rx_valid  output  1  one-`clk` pulse when `d_out` and the error flags update`
- `parity_err  output  1  received parity bit mismatched; valid with `rx_valid`, held after`
- `frame_err  output  1  stop bit sampled low; valid with `rx_valid`, held after`
- `busy  output  1  high in every state except IDLE`

## Operation
- `rx` passes through a 2-flop synchronizer; sync flops reset to 1.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: a high-to-low transition on synced `rx` starts a frame. Tick counter cleared to 0 and bit counter cleared. Next state is START. A line held low does not trigger; a new 1→0 edge is required.
- Tick counter (4 bits) increments on `baud_clk` and wraps 15→0. A bit is sampled on the `baud_clk` at which the counter equals `SAMPLE_MID`.
- START: at the sample point, if `rx` is 1 (glitch), return to IDLE with no `rx_valid`. If `rx` is 0, go to DATA.
- DATA: 8 samples, one per 16 ticks. The first sample is d[7] and bits shift MSB-first. After the 8th sample, go to PARITY.
- PARITY: sample p. Expected p is ~^d when `p_sel` is 0 and ^d when `p_sel` is 1. `p_sel` is sampled at this point.
- STOP: sample the stop bit. On the same edge, load `d_out`, `parity_err` (p≠expected) and `frame_err` (stop==0), then return to IDLE. `rx_valid` asserts the following cycle.
- A frame with errors still updates `d_out` and pulses `rx_valid`.
- `reset` low at any time forces IDLE immediately. A partial frame is discarded.
- Reset values: `d_out`=0x00, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0.

## Timing
- Start detection occurs 2 `clk` after the `rx` falling edge (synchronizer), plus 1 cycle for edge detect.
- Sample points fall at ticks 8, 24, …, 8+16·k after start detection, with k=0..10. Stop is sampled at tick 168 (16·10+8).
- `rx_valid` is high for exactly one `clk`, 1 cycle after the stop-sample tick.
- Return to IDLE occurs mid-stop-bit. A start edge arriving on the following bit boundary is therefore accepted, giving back-to-back frames with no gap.
- `baud_clk` held low freezes all counters. The FSM waits indefinitely and there is no timeout.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each bit value is the 2-of-3 majority of samples at ticks `SAMPLE_MID`, +1 and +2. The decision and state advance occur at tick +2, so `rx_valid` is 2 ticks later than listed above.
- Not defined: a single sample at tick `SAMPLE_MID`.

## Structure
- Package `uart_pkg` holds:
  - the state enum (IDLE/START/DATA/PARITY/STOP, 3-bit)
  - the `OVERSAMPLE`, `SAMPLE_MID` and `DATA_BITS`=8 constants
  - parity encoding constants `PAR_ODD`=0, `PAR_EVEN`=1
- `uart_tx` shares `uart_pkg`.
- One sub-module, `uart_rx_sync`: the 2-flop synchronizer plus registered falling-edge detect. It outputs synced `rx` and a `fall` pulse.

## Test plan
- Loopback from `uart_tx`, `p_sel`=0, byte 0xA5 → one `rx_valid`, `d_out`=0xA5, `parity_err`=0, `frame_err`=0.
- `p_sel`=1, byte 0x3C, parity bit inverted by the bench → `d_out`=0x3C, `parity_err`=1, `frame_err`=0.
- Stop bit forced low, byte 0xFF → `d_out`=0xFF, `frame_err`=1. No new frame is taken until `rx` rises and falls again.
- Start glitch: `rx` low for 4 ticks, then high → no `rx_valid`, FSM back in IDLE, `busy` low.
- Back-to-back frames 0x01 then 0x80 with zero idle gap → two `rx_valid` pulses 176 ticks apart, `d_out`=0x01 then 0x80.
- `reset` asserted at DATA bit 4 of 0x55, then a clean 0x0F frame → outputs at reset values, then a single `rx_valid` with `d_out`=0x0F.
